// File: rtl/mc_loader_pkg.sv
// Shared types and constants for the triangle-memory loader.
//   state_t   : loader FSM states
//   WORD_W    : width of one MC / source word
//   TOP_HI/LO : bounds of the top field (sid for index words, flag for vertex words)
//   TERM_WORD : all-zero phase terminator sent to the triangle memory
package mc_loader_pkg;

    localparam int WORD_W = 128;
    localparam int TOP_HI = 127;
    localparam int TOP_LO = 96;
    localparam logic [WORD_W-1:0] TERM_WORD = 128'h0;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        IDX_REQ   = 4'd1,
        IDX_WAIT  = 4'd2,
        IDX_TERM  = 4'd3,
        VTX_REQ   = 4'd4,
        VTX_WAIT  = 4'd5,
        VTX_TERM  = 4'd6,
        TERM_WAIT = 4'd7,
        DONE      = 4'd8
    } state_t;

endpackage

// File: rtl/mc_triangle_loader.sv
// mc_triangle_loader
// Streams a scene into the triangle memory over the MC write port. It pulls
// num_tri index words and then num_vtx vertex words from an upstream
// valid/ready stream, appends an all-zero terminator after each phase and
// finally strobes done_MC.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start                 1-cycle load request (ignored while busy)
//   num_tri, num_vtx      word counts, sampled on an accepted start, clamped to max
//   src_valid/src_data    upstream word stream
//   src_ready             upstream accept (only in the request states)
//   data_MC, we_MC        registered word and 1-cycle write strobe to the memory
//   rdy_MC                memory ready for the next word
//   done_MC               1-cycle end-of-load strobe
//   busy                  high from the cycle after start through the done_MC cycle
//   load_done             1-cycle pulse after done_MC (or after a num_tri==0 start)
//   err                   (MC_LOADER_SANITIZE_EN only) sticky flag: a source word with
//                         a zero top field was patched; cleared on an accepted start
//
// Build option: define MC_LOADER_SANITIZE_EN to patch zero top fields in source
// words to 32'h1 so they cannot be mistaken for terminators downstream.
module mc_triangle_loader
    import mc_loader_pkg::*;
#(
    parameter  int NUM_TRIANGLE = 512,
    parameter  int NUM_VERTEX   = 2048,
    localparam int BIT_TRIANGLE = $clog2(NUM_TRIANGLE),
    localparam int BIT_VERTEX   = $clog2(NUM_VERTEX)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIT_TRIANGLE:0]   num_tri,
    input  logic [BIT_VERTEX:0]     num_vtx,
    input  logic                    src_valid,
    input  logic [WORD_W-1:0]       src_data,
    output logic                    src_ready,
    output logic [WORD_W-1:0]       data_MC,
    output logic                    we_MC,
    input  logic                    rdy_MC,
    output logic                    done_MC,
`ifdef MC_LOADER_SANITIZE_EN
    output logic                    err,
`endif
    output logic                    busy,
    output logic                    load_done
);

    localparam logic [BIT_TRIANGLE:0] MAX_TRI = (BIT_TRIANGLE+1)'(NUM_TRIANGLE);
    localparam logic [BIT_VERTEX:0]   MAX_VTX = (BIT_VERTEX+1)'(NUM_VERTEX);

    state_t                  state;
    state_t                  state_next;
    logic [BIT_TRIANGLE:0]   tri_tgt;
    logic [BIT_TRIANGLE:0]   idx_cnt;
    logic [BIT_VERTEX:0]     vtx_tgt;
    logic [BIT_VERTEX:0]     vtx_cnt;
    logic                    last_term;   // the vertex-phase terminator has been issued
    logic                    take;
    logic                    issue_term;
    logic                    accept_start;
    logic [WORD_W-1:0]       src_word;

    assign src_ready    = (state == IDX_REQ) || (state == VTX_REQ);
    assign take         = src_valid & src_ready;
    assign issue_term   = (state == IDX_TERM) || (state == VTX_TERM);
    assign accept_start = start && (state == IDLE);

`ifdef MC_LOADER_SANITIZE_EN
    logic top_zero;
    assign top_zero = (src_data[TOP_HI:TOP_LO] == 32'h0);
    assign src_word = top_zero ? {32'h1, src_data[TOP_LO-1:0]} : src_data;

    // Sticky patch flag, cleared by an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept_start) begin
            err <= 1'b0;
        end else if (take && top_zero) begin
            err <= 1'b1;
        end
    end
`else
    assign src_word = src_data;
`endif

    // Next-state logic. rdy_MC is ignored while we_MC is high because the
    // memory has not yet seen the word being written.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && (num_tri != '0)) begin
                    state_next = IDX_REQ;
                end else begin
                    state_next = IDLE;
                end
            end
            IDX_REQ: begin
                if (src_valid) begin
                    state_next = IDX_WAIT;
                end else begin
                    state_next = IDX_REQ;
                end
            end
            IDX_WAIT: begin
                if (!we_MC && rdy_MC) begin
                    state_next = (idx_cnt < tri_tgt) ? IDX_REQ : IDX_TERM;
                end else begin
                    state_next = IDX_WAIT;
                end
            end
            IDX_TERM:  state_next = TERM_WAIT;
            VTX_REQ: begin
                if (src_valid) begin
                    state_next = VTX_WAIT;
                end else begin
                    state_next = VTX_REQ;
                end
            end
            VTX_WAIT: begin
                if (!we_MC && rdy_MC) begin
                    state_next = (vtx_cnt < vtx_tgt) ? VTX_REQ : VTX_TERM;
                end else begin
                    state_next = VTX_WAIT;
                end
            end
            VTX_TERM:  state_next = TERM_WAIT;
            TERM_WAIT: begin
                if (!we_MC && rdy_MC) begin
                    if (last_term) begin
                        state_next = DONE;
                    end else if (vtx_tgt == '0) begin
                        state_next = VTX_TERM;
                    end else begin
                        state_next = VTX_REQ;
                    end
                end else begin
                    state_next = TERM_WAIT;
                end
            end
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // State, registered outputs and word counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data_MC   <= '0;
            we_MC     <= 1'b0;
            done_MC   <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            tri_tgt   <= '0;
            vtx_tgt   <= '0;
            idx_cnt   <= '0;
            vtx_cnt   <= '0;
            last_term <= 1'b0;
        end else begin
            state     <= state_next;
            we_MC     <= take | issue_term;
            done_MC   <= (state_next == DONE);
            busy      <= (state_next != IDLE);
            load_done <= (state == DONE) || (accept_start && (num_tri == '0));

            if (take) begin
                data_MC <= src_word;
            end else if (issue_term) begin
                data_MC <= TERM_WORD;
            end

            if (accept_start) begin
                tri_tgt   <= (num_tri > MAX_TRI) ? MAX_TRI : num_tri;
                vtx_tgt   <= (num_vtx > MAX_VTX) ? MAX_VTX : num_vtx;
                idx_cnt   <= '0;
                vtx_cnt   <= '0;
                last_term <= 1'b0;
            end else begin
                if (take && (state == IDX_REQ) && (idx_cnt < tri_tgt)) begin
                    idx_cnt <= idx_cnt + 1'b1;
                end
                if (take && (state == VTX_REQ) && (vtx_cnt < vtx_tgt)) begin
                    vtx_cnt <= vtx_cnt + 1'b1;
                end
                if (state == VTX_TERM) begin
                    last_term <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_triangle_loader.sv
// Randomized self-checking bench for mc_triangle_loader. A queue of expected
// MC writes (index words, zero, vertex words, zero) is built from the load
// request and compared against every we_MC strobe; a small receiver model
// drives rdy_MC low for a random time after each write.
module tb_mc_triangle_loader;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [9:0]    num_tri;
    logic [11:0]   num_vtx;
    logic          src_valid;
    logic [127:0]  src_data;
    logic          src_ready;
    logic [127:0]  data_MC;
    logic          we_MC;
    logic          rdy_MC;
    logic          done_MC;
    logic          busy;
    logic          load_done;
`ifdef MC_LOADER_SANITIZE_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    mc_triangle_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_tri   (num_tri),
        .num_vtx   (num_vtx),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .data_MC   (data_MC),
        .we_MC     (we_MC),
        .rdy_MC    (rdy_MC),
        .done_MC   (done_MC),
`ifdef MC_LOADER_SANITIZE_EN
        .err       (err),
`endif
        .busy      (busy),
        .load_done (load_done)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [127:0]  src_words[$];
    logic [127:0]  exp_q[$];
    int            src_idx  = 0;
    int            we_cnt   = 0;
    int            done_cnt = 0;
    int            ld_cnt   = 0;
    bit            prev_done = 1'b0;
    bit            zero_mode = 1'b0;
    bit            toggle_mode = 1'b0;
    bit            tog = 1'b0;
    bit            rdy_hold = 1'b0;
    int            rx_max  = 0;
    int            rx_wait = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand_word();
        logic [31:0] top;
        top = $urandom;
        if (top == 32'h0) top = 32'h1;
        return {top, $urandom, $urandom, $urandom};
    endfunction

    // What the memory should receive for a given source word.
    function automatic logic [127:0] expect_word(input logic [127:0] w);
`ifdef MC_LOADER_SANITIZE_EN
        if (w[127:96] == 32'h0) return {32'h1, w[95:0]};
`endif
        return w;
    endfunction

    // Count upstream transfers.
    always @(posedge clk) begin
        if (!rst && src_valid && src_ready) src_idx++;
    end

    // Monitor, receiver model and source driver, all away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
            rx_wait   = 0;
            rdy_MC    = 1'b0;
            src_valid = 1'b0;
            src_data  = '0;
        end else begin
            check_eq("src_ready_legal", src_ready & (we_MC | ~busy), 1'b0);
            if (we_MC) begin
                we_cnt++;
                if (exp_q.size() == 0) check_eq("we_unexpected", 1'b1, 1'b0);
                else check_eq("data_MC", data_MC, exp_q.pop_front());
            end
            if (done_MC) begin
                done_cnt++;
                check_eq("done_all_written", exp_q.size(), 0);
                check_eq("busy_at_done", busy, 1'b1);
            end
            if (load_done) begin
                ld_cnt++;
                check_eq("load_done_timing", prev_done | zero_mode, 1'b1);
            end
            prev_done = done_MC;

            if (we_MC) rx_wait = $urandom_range(rx_max, 0);
            else if (rx_wait > 0) rx_wait--;
            rdy_MC = !rdy_hold && (rx_wait == 0);

            tog = ~tog;
            if (src_idx < src_words.size()) begin
                src_data  = src_words[src_idx];
                src_valid = toggle_mode ? tog : 1'b1;
            end else begin
                src_data  = '0;
                src_valid = 1'b0;
            end
        end
    end

    task automatic prep_load(input int ntri, input int nvtx, input bit bad_first);
        int et;
        int ev;
        logic [127:0] w;
        et = (ntri > 512) ? 512 : ntri;
        ev = (nvtx > 2048) ? 2048 : nvtx;
        src_words.delete();
        exp_q.delete();
        src_idx = 0; we_cnt = 0; done_cnt = 0; ld_cnt = 0; zero_mode = 1'b0;
        for (int i = 0; i < et; i++) begin
            w = rand_word();
            if (i == 0 && bad_first) w[127:96] = 32'h0;
            src_words.push_back(w);
            exp_q.push_back(expect_word(w));
        end
        exp_q.push_back(128'h0);
        for (int i = 0; i < ev; i++) begin
            w = rand_word();
            src_words.push_back(w);
            exp_q.push_back(expect_word(w));
        end
        exp_q.push_back(128'h0);
    endtask

    task automatic kick(input int ntri, input int nvtx);
        @(negedge clk);
        start = 1'b1; num_tri = ntri[9:0]; num_vtx = nvtx[11:0];
        @(negedge clk);
        start = 1'b0;
`ifdef MC_LOADER_SANITIZE_EN
        check_eq("err_cleared_on_start", err, 1'b0);
`endif
    endtask

    task automatic finish_load(input int ntri, input int nvtx, input string tag);
        int et;
        int ev;
        int cyc;
        et = (ntri > 512) ? 512 : ntri;
        ev = (nvtx > 2048) ? 2048 : nvtx;
        cyc = 0;
        while (ld_cnt == 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check_eq({tag, "_timeout"}, cyc < 20000, 1'b1);
        check_eq({tag, "_we_count"}, we_cnt, et + ev + 2);
        check_eq({tag, "_done_count"}, done_cnt, 1);
        check_eq({tag, "_ld_count"}, ld_cnt, 1);
        check_eq({tag, "_exp_left"}, exp_q.size(), 0);
        check_eq({tag, "_src_taken"}, src_idx, et + ev);
        check_eq({tag, "_busy_after"}, busy, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_data_MC"}, data_MC, 128'h0);
        check_eq({tag, "_we_MC"}, we_MC, 1'b0);
        check_eq({tag, "_done_MC"}, done_MC, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_load_done"}, load_done, 1'b0);
        check_eq({tag, "_src_ready"}, src_ready, 1'b0);
    endtask

    initial begin
        logic [127:0] held;
        int cyc;
        int nt;
        int nv;

        rst = 1'b1; start = 1'b0; num_tri = '0; num_vtx = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Basic 2 index / 3 vertex load.
        rx_max = 4;
        prep_load(2, 3, 1'b0); kick(2, 3); finish_load(2, 3, "basic");

        // Memory not ready for 20 cycles after the first word.
        rdy_hold = 1'b1; rx_max = 1;
        prep_load(3, 2, 1'b0); kick(3, 2);
        cyc = 0;
        while (we_cnt < 1 && cyc < 200) begin @(negedge clk); cyc++; end
        check_eq("hold_first_we_timeout", cyc < 200, 1'b1);
        held = data_MC;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("hold_no_second_we", we_cnt, 1);
            check_eq("hold_data_stable", data_MC, held);
        end
        rdy_hold = 1'b0;
        finish_load(3, 2, "hold");

        // Source stalling every other cycle.
        toggle_mode = 1'b1; rx_max = 2;
        prep_load(4, 5, 1'b0); kick(4, 5); finish_load(4, 5, "toggle");
        toggle_mode = 1'b0;

        // num_tri == 0: immediate load_done, no traffic.
        src_words.delete(); exp_q.delete();
        we_cnt = 0; done_cnt = 0; ld_cnt = 0; zero_mode = 1'b1;
        @(negedge clk);
        start = 1'b1; num_tri = 10'd0; num_vtx = 12'd5;
        @(negedge clk);
        start = 1'b0;
        check_eq("zero_load_done", load_done, 1'b1);
        check_eq("zero_busy", busy, 1'b0);
        repeat (10) @(negedge clk);
        check_eq("zero_no_we", we_cnt, 0);
        check_eq("zero_no_done", done_cnt, 0);
        check_eq("zero_one_ld", ld_cnt, 1);
        zero_mode = 1'b0;

        // One index word, no vertices: idx, zero, zero, done.
        prep_load(1, 0, 1'b0); kick(1, 0); finish_load(1, 0, "novtx");

        // Start while busy must be ignored.
        prep_load(3, 4, 1'b0); kick(3, 4);
        repeat (8) @(negedge clk);
        start = 1'b1; num_tri = 10'd9; num_vtx = 12'd9;
        @(negedge clk);
        start = 1'b0;
        finish_load(3, 4, "busy_start");

        // Reset in the middle of the vertex phase.
        prep_load(3, 10, 1'b0); kick(3, 10);
        cyc = 0;
        while (we_cnt < 6 && cyc < 1000) begin @(negedge clk); cyc++; end
        check_eq("midrst_reach_vtx", cyc < 1000, 1'b1);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prep_load(4, 4, 1'b0); kick(4, 4); finish_load(4, 4, "after_rst");

        // Oversized count clamps to NUM_TRIANGLE.
        rx_max = 0;
        prep_load(1000, 6, 1'b0); kick(1000, 6); finish_load(1000, 6, "clamp");

        // Random loads.
        for (int k = 0; k < 4; k++) begin
            nt = $urandom_range(12, 1);
            nv = $urandom_range(12, 0);
            toggle_mode = $urandom_range(1, 0);
            rx_max = $urandom_range(4, 0);
            prep_load(nt, nv, 1'b0); kick(nt, nv); finish_load(nt, nv, "random");
        end
        toggle_mode = 1'b0;

`ifdef MC_LOADER_SANITIZE_EN
        prep_load(2, 2, 1'b1); kick(2, 2); finish_load(2, 2, "sanitize");
        check_eq("sanitize_err_set", err, 1'b1);
        prep_load(1, 1, 1'b0); kick(1, 1); finish_load(1, 1, "sanitize_clear");
        check_eq("sanitize_err_stays_clear", err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
